// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side hazard bus between the core pipeline and pipe_hazard_ctrl.
// The pipeline uses the master modport; the hazard controller uses the slave modport.
interface pipe_hazard_ctrl_if;
  logic        dec_valid_i;
  logic [4:0]  dec_read_addr_a_i;
  logic [4:0]  dec_read_addr_b_i;
  logic        dec_uses_a_i;
  logic        dec_uses_b_i;
  logic [4:0]  dec_write_addr_i;
  logic        dec_int_write_enable_i;
  logic        dec_is_load_i;
  logic        dec_is_mul_i;
  logic        exe_branch_taken_i;
  logic [31:0] exe_branch_target_i;
  logic        stall_core_o;
  logic        kill_o;
  logic        flush_fetch_o;
  logic [31:0] redirect_pc_o;

  modport master (
    output dec_valid_i, dec_read_addr_a_i, dec_read_addr_b_i, dec_uses_a_i, dec_uses_b_i,
           dec_write_addr_i, dec_int_write_enable_i, dec_is_load_i, dec_is_mul_i,
           exe_branch_taken_i, exe_branch_target_i,
    input  stall_core_o, kill_o, flush_fetch_o, redirect_pc_o
  );

  modport slave (
    input  dec_valid_i, dec_read_addr_a_i, dec_read_addr_b_i, dec_uses_a_i, dec_uses_b_i,
           dec_write_addr_i, dec_int_write_enable_i, dec_is_load_i, dec_is_mul_i,
           exe_branch_taken_i, exe_branch_target_i,
    output stall_core_o, kill_o, flush_fetch_o, redirect_pc_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: RAW stalls, multi-cycle multiply freeze, branch flush.
// Define PIPE_HAZARD_FWD_EN when the core has full forwarding (load-use checks only).
module pipe_hazard_ctrl #(
  parameter int MUL_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);

  logic       exe_we_reg, exe_we_next;
  logic [4:0] exe_rd_reg, exe_rd_next;
  logic       exe_load_reg, exe_load_next;
  logic       mem_we_reg, mem_we_next;
  logic [4:0] mem_rd_reg, mem_rd_next;
  logic [7:0] mul_cnt_reg, mul_cnt_next;

  logic       busy;
  logic       hazard;
  logic       mul_enter;
  logic [4:0] src_addr [2];
  logic       src_use  [2];
  logic [1:0] exe_hit;
  logic [1:0] mem_hit;

  assign busy        = (mul_cnt_reg != 8'd0);
  assign src_addr[0] = bus.dec_read_addr_a_i;
  assign src_addr[1] = bus.dec_read_addr_b_i;
  assign src_use[0]  = bus.dec_uses_a_i;
  assign src_use[1]  = bus.dec_uses_b_i;

  // x0 is hardwired zero, so a write to it never creates a dependency.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign exe_hit[gi] = src_use[gi] && exe_we_reg && (exe_rd_reg != 5'd0)
                           && (exe_rd_reg == src_addr[gi]);
      assign mem_hit[gi] = src_use[gi] && mem_we_reg && (mem_rd_reg != 5'd0)
                           && (mem_rd_reg == src_addr[gi]);
    end
  endgenerate

`ifdef PIPE_HAZARD_FWD_EN
  // Forwarding covers everything except a load result still in EXE.
  logic [1:0] unused_mem_hit;
  assign unused_mem_hit = mem_hit;
  assign hazard = exe_load_reg && (|exe_hit);
`else
  logic unused_exe_load;
  assign unused_exe_load = exe_load_reg;
  assign hazard = (|exe_hit) || (|mem_hit);
`endif

  always_comb begin
    bus.stall_core_o  = 1'b0;
    bus.kill_o        = 1'b0;
    bus.flush_fetch_o = 1'b0;
    bus.redirect_pc_o = rst_i ? 32'd0 : bus.exe_branch_target_i;
    if (!rst_i) begin
      if (busy) begin
        // The multiply owns EXE; a branch flag seen now is not a real resolution.
        bus.stall_core_o = 1'b1;
      end else if (bus.exe_branch_taken_i) begin
        bus.kill_o        = 1'b1;
        bus.flush_fetch_o = 1'b1;
      end else if (bus.dec_valid_i && hazard) begin
        bus.stall_core_o = 1'b1;
        bus.kill_o       = 1'b1;
      end
    end
  end

  assign mul_enter = bus.dec_valid_i && bus.dec_is_mul_i && !bus.stall_core_o && !bus.kill_o;

  always_comb begin
    exe_we_next   = exe_we_reg;
    exe_rd_next   = exe_rd_reg;
    exe_load_next = exe_load_reg;
    mem_we_next   = exe_we_reg;
    mem_rd_next   = exe_rd_reg;
    mul_cnt_next  = mul_cnt_reg;

    if (bus.kill_o) begin
      exe_we_next   = 1'b0;
      exe_rd_next   = 5'd0;
      exe_load_next = 1'b0;
    end else if (!bus.stall_core_o) begin
      exe_we_next   = bus.dec_valid_i && bus.dec_int_write_enable_i;
      exe_rd_next   = bus.dec_write_addr_i;
      exe_load_next = bus.dec_is_load_i;
    end

    // While the multiply is held in EXE, nothing advances into MEM.
    if (busy) begin
      mem_we_next = 1'b0;
      mem_rd_next = 5'd0;
    end

    if (mul_enter) begin
      mul_cnt_next = MUL_LOAD;
    end else if (busy) begin
      mul_cnt_next = mul_cnt_reg - 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exe_we_reg   <= 1'b0;
      exe_rd_reg   <= 5'd0;
      exe_load_reg <= 1'b0;
      mem_we_reg   <= 1'b0;
      mem_rd_reg   <= 5'd0;
      mul_cnt_reg  <= 8'd0;
    end else begin
      exe_we_reg   <= exe_we_next;
      exe_rd_reg   <= exe_rd_next;
      exe_load_reg <= exe_load_next;
      mem_we_reg   <= mem_we_next;
      mem_rd_reg   <= mem_rd_next;
      mul_cnt_reg  <= mul_cnt_next;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: two instances (MUL_CYCLES=4 and 1) share one stimulus.
// Inputs change on the falling edge; combinational outputs are checked 1 ns later.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus4 ();
  pipe_hazard_ctrl_if bus1 ();

  pipe_hazard_ctrl #(.MUL_CYCLES(4)) dut4 (.clk_i(clk), .rst_i(rst), .bus(bus4));
  pipe_hazard_ctrl #(.MUL_CYCLES(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

  logic [2:0] f4, f1;
  assign f4 = {bus4.stall_core_o, bus4.kill_o, bus4.flush_fetch_o};
  assign f1 = {bus1.stall_core_o, bus1.kill_o, bus1.flush_fetch_o};

  task automatic set_dec(input logic v, input logic [4:0] ra, input logic ua,
                         input logic [4:0] rb, input logic ub, input logic [4:0] rd,
                         input logic we, input logic ld, input logic mul);
    bus4.dec_valid_i = v;  bus4.dec_read_addr_a_i = ra; bus4.dec_uses_a_i = ua;
    bus4.dec_read_addr_b_i = rb; bus4.dec_uses_b_i = ub; bus4.dec_write_addr_i = rd;
    bus4.dec_int_write_enable_i = we; bus4.dec_is_load_i = ld; bus4.dec_is_mul_i = mul;
    bus1.dec_valid_i = v;  bus1.dec_read_addr_a_i = ra; bus1.dec_uses_a_i = ua;
    bus1.dec_read_addr_b_i = rb; bus1.dec_uses_b_i = ub; bus1.dec_write_addr_i = rd;
    bus1.dec_int_write_enable_i = we; bus1.dec_is_load_i = ld; bus1.dec_is_mul_i = mul;
  endtask

  task automatic set_br(input logic t, input logic [31:0] tgt);
    bus4.exe_branch_taken_i = t; bus4.exe_branch_target_i = tgt;
    bus1.exe_branch_taken_i = t; bus1.exe_branch_target_i = tgt;
  endtask

  task automatic idle();
    set_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    set_br(1'b0, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    set_dec(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1);
    set_br(1'b1, 32'hDEAD_BEEF);
    #1;
    n_checks++;
    if (f4 !== 3'b000 || bus4.redirect_pc_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: stall/kill/flush=%b pc=%h, want 000 pc=00000000", f4, bus4.redirect_pc_o);
    end else $display("ok   reset_outputs: stall/kill/flush=%b pc=%h", f4, bus4.redirect_pc_o);
    @(negedge clk);
    rst = 1'b0;
    idle();
    bus4.exe_branch_target_i = 32'h0000_1234;
    #1;
    n_checks++;
    if (f4 !== 3'b000 || bus4.redirect_pc_o !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL post_reset_idle: stall/kill/flush=%b pc=%h, want 000 pc=00001234", f4, bus4.redirect_pc_o);
    end else $display("ok   post_reset_idle: stall/kill/flush=%b pc=%h", f4, bus4.redirect_pc_o);
    bus4.exe_branch_target_i = 32'd0;
  endtask

  // Load x5 then read x5 on A; afterwards the same with destination x0.
  task automatic test_load_use();
    logic [2:0] exp_c2;
`ifdef PIPE_HAZARD_FWD_EN
    exp_c2 = 3'b000;
`else
    exp_c2 = 3'b110;
`endif
    drain();
    @(negedge clk);
    set_dec(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (f4 !== 3'b000) begin
      n_fail++; $display("FAIL load_issue: stall/kill/flush=%b, want 000", f4);
    end else $display("ok   load_issue: stall/kill/flush=%b", f4);
    @(negedge clk);
    set_dec(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (f4 !== 3'b110) begin
      n_fail++; $display("FAIL load_use_c1: stall/kill/flush=%b, want 110", f4);
    end else $display("ok   load_use_c1: stall/kill/flush=%b", f4);
    @(negedge clk);
    #1;
    n_checks++;
    if (f4 !== exp_c2) begin
      n_fail++; $display("FAIL load_use_c2: stall/kill/flush=%b, want %b", f4, exp_c2);
    end else $display("ok   load_use_c2: stall/kill/flush=%b", f4);
    @(negedge clk);
    #1;
    n_checks++;
    if (f4 !== 3'b000) begin
      n_fail++; $display("FAIL load_use_c3: stall/kill/flush=%b, want 000", f4);
    end else $display("ok   load_use_c3: stall/kill/flush=%b", f4);
    drain();
    @(negedge clk);
    set_dec(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (f4 !== 3'b000) begin
      n_fail++; $display("FAIL load_x0: stall/kill/flush=%b, want 000", f4);
    end else $display("ok   load_x0: stall/kill/flush=%b", f4);
  endtask

  // add x7 then sub reading x7 on B: two stalls without forwarding, none with it.
  task automatic test_raw_alu();
    logic [2:0] exp_s;
`ifdef PIPE_HAZARD_FWD_EN
    exp_s = 3'b000;
`else
    exp_s = 3'b110;
`endif
    drain();
    @(negedge clk);
    set_dec(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    set_dec(1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      n_checks++;
      if (f4 !== ((c < 2) ? exp_s : 3'b000)) begin
        n_fail++;
        $display("FAIL raw_alu_c%0d: stall/kill/flush=%b, want %b", c, f4, (c < 2) ? exp_s : 3'b000);
      end else $display("ok   raw_alu_c%0d: stall/kill/flush=%b", c, f4);
    end
  endtask

  task automatic test_mul_busy();
    drain();
    @(negedge clk);
    set_dec(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (f4 !== 3'b000) begin
      n_fail++; $display("FAIL mul_issue: stall/kill/flush=%b, want 000", f4);
    end else $display("ok   mul_issue: stall/kill/flush=%b", f4);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      set_dec(1'b1, 5'd3, 1'b0, 5'd4, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
      set_br(c == 2, 32'h0000_0200);
      #1;
      n_checks++;
      if (f4 !== ((c <= 3) ? 3'b100 : 3'b000)) begin
        n_fail++;
        $display("FAIL mul_busy_c%0d: stall/kill/flush=%b, want %b", c, f4, (c <= 3) ? 3'b100 : 3'b000);
      end else $display("ok   mul_busy_c%0d: stall/kill/flush=%b", c, f4);
    end
    set_br(1'b0, 32'd0);
  endtask

  // Taken branch while decode depends on EXE: flush wins, the dependent instruction is dropped.
  task automatic test_branch_flush();
    logic [2:0] exp_after;
`ifdef PIPE_HAZARD_FWD_EN
    exp_after = 3'b000;
`else
    exp_after = 3'b110;
`endif
    drain();
    @(negedge clk);
    set_dec(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    set_dec(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    set_br(1'b1, 32'h0000_0100);
    #1;
    n_checks++;
    if (f4 !== 3'b011 || bus4.redirect_pc_o !== 32'h0000_0100) begin
      n_fail++;
      $display("FAIL branch_flush: stall/kill/flush=%b pc=%h, want 011 pc=00000100", f4, bus4.redirect_pc_o);
    end else $display("ok   branch_flush: stall/kill/flush=%b pc=%h", f4, bus4.redirect_pc_o);
    @(negedge clk);
    set_br(1'b0, 32'd0);
    #1;
    n_checks++;
    if (f4 !== exp_after) begin
      n_fail++; $display("FAIL branch_after: stall/kill/flush=%b, want %b", f4, exp_after);
    end else $display("ok   branch_after: stall/kill/flush=%b", f4);
  endtask

  task automatic test_reset_mid_mul();
    drain();
    @(negedge clk);
    set_dec(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    set_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (f4 !== 3'b100) begin
      n_fail++; $display("FAIL rst_mul_busy1: stall/kill/flush=%b, want 100", f4);
    end else $display("ok   rst_mul_busy1: stall/kill/flush=%b", f4);
    @(negedge clk);
    rst = 1'b1;
    set_br(1'b1, 32'h0000_0300);
    #1;
    n_checks++;
    if (f4 !== 3'b000 || bus4.redirect_pc_o !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mul_during: stall/kill/flush=%b pc=%h, want 000 pc=00000000", f4, bus4.redirect_pc_o);
    end else $display("ok   rst_mul_during: stall/kill/flush=%b pc=%h", f4, bus4.redirect_pc_o);
    @(negedge clk);
    rst = 1'b0;
    set_br(1'b0, 32'd0);
    set_dec(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      n_checks++;
      if (f4 !== 3'b000) begin
        n_fail++; $display("FAIL rst_mul_after_c%0d: stall/kill/flush=%b, want 000", c, f4);
      end else $display("ok   rst_mul_after_c%0d: stall/kill/flush=%b", c, f4);
      set_dec(1'b1, 5'd20, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    drain();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      set_dec(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'(13 + c), 1'b1, 1'b0, 1'b1);
      #1;
      n_checks++;
      if (f1 !== 3'b000) begin
        n_fail++; $display("FAIL mul1_b2b_c%0d: stall/kill/flush=%b, want 000", c, f1);
      end else $display("ok   mul1_b2b_c%0d: stall/kill/flush=%b", c, f1);
    end
    // The MUL_CYCLES=4 instance saw the same first multiply and must be busy now.
    n_checks++;
    if (f4 !== 3'b100) begin
      n_fail++; $display("FAIL mul4_contrast: stall/kill/flush=%b, want 100", f4);
    end else $display("ok   mul4_contrast: stall/kill/flush=%b", f4);
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_raw_alu();
    test_mul_busy();
    test_branch_flush();
    test_reset_mid_mul();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

- Pipeline control block that drives the stall and kill inputs of the dec→exe latch and the fetch/decode flush.
- Keeps a shadow of the destination registers held in the EXE and MEM stages.
- Detects read-after-write hazards against the instruction in decode, freezes the core while a multi-cycle multiply occupies EXE, and flushes on taken branches resolved in EXE.

## Interface
Parameters:
- MUL_CYCLES, 4, EXE occupancy of a multiply in cycles; legal range 1..256.

Ports:
- clk_i  in  1  core clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- dec_valid_i  in  1  decode holds a valid instruction.
- dec_read_addr_a_i  in  5  source register A.
- dec_read_addr_b_i  in  5  source register B.
- dec_uses_a_i  in  1  instruction reads A.
- dec_uses_b_i  in  1  instruction reads B.
- dec_write_addr_i  in  5  destination register.
- dec_int_write_enable_i  in  1  instruction writes the integer register file.
- dec_is_load_i  in  1  instruction is a load.
- dec_is_mul_i  in  1  instruction is a multiply.
- exe_branch_taken_i  in  1  EXE resolved a taken branch or jump this cycle.
- exe_branch_target_i  in  32  target PC of that branch.
- stall_core_o  out  1  freeze fetch, decode and the dec→exe latch; feeds the latch stall_core_i.
- kill_o  out  1  clear the dec→exe latch; feeds the latch kill_i, which has priority over stall.
- flush_fetch_o  out  1  invalidate fetch and decode.
- redirect_pc_o  out  32  new fetch PC, valid when flush_fetch_o=1.

## Operation
State:
- EXE slot {we, rd, load}: mirrors the dec→exe latch.
- MEM slot {we, rd}.
- mul counter, 8 bit.
- "busy" = counter != 0.

Output priority, evaluated combinationally from state and inputs:
1. rst_i=1: all outputs 0.
2. busy: stall_core_o=1, kill_o=0, flush_fetch_o=0. The latch holds the multiply and exe_branch_taken_i is ignored.
3. exe_branch_taken_i: kill_o=1, flush_fetch_o=1, stall_core_o=0, redirect_pc_o=exe_branch_target_i.
4. Hazard (dec_valid_i=1): stall_core_o=1, kill_o=1, which holds decode and inserts a bubble into EXE.
5. Otherwise: all outputs 0.

redirect_pc_o always passes exe_branch_target_i through, but is 0 during reset.

Hazard match: a slot with we=1, rd!=0 and rd equal to a source register that is in use (dec_uses_a_i/dec_read_addr_a_i, dec_uses_b_i/dec_read_addr_b_i). Register 0 never matches.

Slot update each edge:
- rst_i: both slots cleared, counter=0.
- EXE slot:
  - cleared when kill_o=1;
  - held when stall_core_o=1 and kill_o=0;
  - otherwise loaded with {dec_valid_i & dec_int_write_enable_i, dec_write_addr_i, dec_is_load_i}.
- MEM slot:
  - cleared when busy (bubbles downstream);
  - otherwise loaded with the EXE slot's {we, rd}.
- Counter:
  - loads MUL_CYCLES-1 when a multiply enters EXE (dec_valid_i & dec_is_mul_i & no stall & no kill);
  - otherwise decrements while nonzero.
  - With MUL_CYCLES=1 the core is never busy.

## Timing
- All outputs are combinational from state plus the current-cycle inputs; there are no registered outputs.
- Load-use stall lasts exactly 1 cycle with forwarding enabled.
- Multiply busy covers MUL_CYCLES-1 cycles, starting the cycle after the multiply enters EXE.
- A branch and a hazard in the same cycle produce flush only; the decode instruction is discarded.
- Reset asserted mid-multiply: counter=0 on the next edge and no residual stall.

## Configuration
- PIPE_HAZARD_FWD_EN defined: full forwarding exists. Only the EXE slot is checked, and only when its load=1 (load-use hazard). The MEM slot is tracked but never matched.
- Undefined: no forwarding. Both the EXE and MEM slots are checked regardless of load, so a dependent instruction stalls up to 2 cycles.

## Test plan
- Forwarding: load x5 in EXE, decode reads x5 on A. Required: stall_core_o=1 and kill_o=1 for 1 cycle, then 0. Repeat with destination x0: no stall.
- No forwarding: add x7 then dependent sub reading x7 on B. Required: 2 stall cycles; EXE slot holds bubble, MEM slot holds x7, then clear.
- MUL_CYCLES=4: multiply enters EXE. Required: stall_core_o=1, kill_o=0 for 3 cycles. exe_branch_taken_i=1 pulsed in the 2nd busy cycle is ignored (flush_fetch_o=0).
- Taken branch with target 0x0000_0100 while decode has a hazard. Required: kill_o=1, flush_fetch_o=1, redirect_pc_o=0x100, stall_core_o=0.
- rst_i asserted in the 2nd busy cycle. Required: all outputs 0 during reset; after release, counter=0, both slots empty, and an independent instruction flows with no stall.
- MUL_CYCLES=1: back-to-back multiplies. Required: no stall cycles.
